// File: rtl/adc_sample_packer.sv
// ADC pair packer into a 32-bit FWFT FIFO; word visible 2 cycles after its second sample; no input backpressure, a full FIFO drops the word and sets sticky overflow.
// Define ADC_PACK_TLAST_EN to add m_last, driven by a modulo-BURST_LEN read-beat counter.
module adc_sample_packer #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int FIFO_DEPTH   = 32,
  parameter int BURST_LEN    = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          enable,
  input  logic [SAMPLE_WIDTH-1:0]       adc_data,
  input  logic                          adc_valid,
  output logic [31:0]                   m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          burst_avail,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
`ifdef ADC_PACK_TLAST_EN
  output logic                          m_last,
`endif
  input  logic                          clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L  = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] BURST_L  = BURST_LEN[AW:0];
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  localparam logic [0:0] HALF_EMPTY = 1'b0;
  localparam logic [0:0] HALF_FULL  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [15:0] held_q, held_d;
  logic        wr_vld_q, wr_vld_d;
  logic [31:0] wr_dat_q, wr_dat_d;
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] fill_q, fill_d;
  logic        vld_q;
  logic        burst_q;
  logic        ovf_q, ovf_d;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [15:0] samp_ext;
  logic        rd;
  logic        wr_ok;
  logic        drop;

  assign samp_ext = 16'(adc_data);

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    wr_vld_d = 1'b0;
    wr_dat_d = wr_dat_q;
    if (!enable) begin
      state_d = HALF_EMPTY;
      held_d  = '0;
    end else if (adc_valid) begin
      case (state_q)
        HALF_EMPTY: begin
          held_d  = samp_ext;
          state_d = HALF_FULL;
        end
        HALF_FULL: begin
          wr_vld_d = 1'b1;
          wr_dat_d = {samp_ext, held_q};
          state_d  = HALF_EMPTY;
        end
        default: state_d = HALF_EMPTY;
      endcase
    end
  end

  // A same-cycle read frees a slot, so a full FIFO still accepts the write.
  always_comb begin
    rd     = vld_q && m_ready;
    wr_ok  = wr_vld_q && ((fill_q != DEPTH_L) || rd);
    drop   = wr_vld_q && !wr_ok;
    wptr_d = wr_ok ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = rd ? rptr_q + PTR_ONE : rptr_q;
    fill_d = wptr_d - rptr_d;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_overflow) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= HALF_EMPTY;
      held_q   <= '0;
      wr_vld_q <= 1'b0;
      wr_dat_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fill_q   <= '0;
      vld_q    <= 1'b0;
      burst_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      wr_vld_q <= wr_vld_d;
      wr_dat_q <= wr_dat_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fill_q   <= fill_d;
      vld_q    <= (fill_d != '0);
      burst_q  <= (fill_d >= BURST_L);
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_ok) begin
      mem_q[wptr_q[AW-1:0]] <= wr_dat_q;
    end
  end

  assign m_data      = vld_q ? mem_q[rptr_q[AW-1:0]] : '0;
  assign m_valid     = vld_q;
  assign burst_avail = burst_q;
  assign fill_level  = fill_q;
  assign overflow    = ovf_q;

`ifdef ADC_PACK_TLAST_EN
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LB = BURST_LEN - 1;
  localparam logic [BW-1:0] LAST_BEAT = LB[BW-1:0];
  localparam logic [BW-1:0] BEAT_ONE  = {{(BW-1){1'b0}}, 1'b1};

  logic          en_q;
  logic [BW-1:0] beat_q;

  // Beat phase restarts whenever capture is switched off.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en_q   <= 1'b0;
      beat_q <= '0;
    end else begin
      en_q <= enable;
      if (en_q && !enable) begin
        beat_q <= '0;
      end else if (rd) begin
        beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_ONE;
      end
    end
  end

  assign m_last = vld_q && (beat_q == LAST_BEAT);
`endif

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed and random bench for adc_sample_packer against a queue-based reference model.
module tb_adc_sample_packer;

  localparam int SW    = 12;
  localparam int DEPTH = 32;
  localparam int BURST = 8;

  logic                     ACLK;
  logic                     ARESETN;
  logic                     enable;
  logic [SW-1:0]            adc_data;
  logic                     adc_valid;
  logic [31:0]              m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     burst_avail;
  logic [$clog2(DEPTH):0]   fill_level;
  logic                     overflow;
  logic                     clr_overflow;
`ifdef ADC_PACK_TLAST_EN
  logic                     m_last;
`endif

  adc_sample_packer #(
    .SAMPLE_WIDTH (SW),
    .FIFO_DEPTH   (DEPTH),
    .BURST_LEN    (BURST)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .enable       (enable),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .burst_avail  (burst_avail),
    .fill_level   (fill_level),
    .overflow     (overflow),
`ifdef ADC_PACK_TLAST_EN
    .m_last       (m_last),
`endif
    .clr_overflow (clr_overflow)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int n_assert = 0;
  int n_fail   = 0;

  bit [31:0] mq[$];
  bit        half;
  bit [15:0] held;
  bit        pend_vld;
  bit [31:0] pend_dat;
  bit        ovf;
  int        beat;
  bit        prev_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    half     = 1'b0;
    held     = '0;
    pend_vld = 1'b0;
    pend_dat = '0;
    ovf      = 1'b0;
    beat     = 0;
    prev_en  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    chk("fill_level", 32'(fill_level), 32'(mq.size()));
    chk("burst_avail", 32'(burst_avail), 32'(mq.size() >= BURST));
    chk("overflow", 32'(overflow), 32'(ovf));
    if (mq.size() != 0) chk("m_data", m_data, mq[0]);
`ifdef ADC_PACK_TLAST_EN
    chk("m_last", 32'(m_last), 32'(mq.size() != 0 && beat == BURST - 1));
`endif
  endtask

  // One clock: drive inputs, advance the model with the values seen at the edge, then compare.
  task automatic step(input bit en, input bit vld, input bit [SW-1:0] d, input bit rdy, input bit clr);
    bit        rd_m;
    bit        drop_m;
    bit        npend_vld;
    bit [31:0] npend;
    int        sz;
    enable       = en;
    adc_valid    = vld;
    adc_data     = d;
    m_ready      = rdy;
    clr_overflow = clr;
    @(posedge ACLK);
    sz   = mq.size();
    rd_m = (sz != 0) && rdy;
    if (prev_en && !en) beat = 0;
    else if (rd_m) beat = (beat + 1) % BURST;
    prev_en = en;
    if (rd_m) void'(mq.pop_front());
    drop_m = 1'b0;
    if (pend_vld) begin
      if (sz < DEPTH || rd_m) mq.push_back(pend_dat);
      else drop_m = 1'b1;
    end
    if (drop_m) ovf = 1'b1;
    else if (clr) ovf = 1'b0;
    npend_vld = 1'b0;
    npend     = '0;
    if (!en) begin
      half = 1'b0;
    end else if (vld) begin
      if (!half) begin
        held = 16'(d);
        half = 1'b1;
      end else begin
        npend_vld = 1'b1;
        npend     = {16'(d), held};
        half      = 1'b0;
      end
    end
    pend_vld = npend_vld;
    pend_dat = npend;
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m_data"}, m_data, 32'h0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'h0);
    chk({tag, "_burst"}, 32'(burst_avail), 32'h0);
    chk({tag, "_fill"}, 32'(fill_level), 32'h0);
    chk({tag, "_ovf"}, 32'(overflow), 32'h0);
`ifdef ADC_PACK_TLAST_EN
    chk({tag, "_m_last"}, 32'(m_last), 32'h0);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 8 && mq.size() != 0; i++) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", 32'(m_valid), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    enable = 1'b0; adc_valid = 1'b0; adc_data = '0; m_ready = 1'b0; clr_overflow = 1'b0;
    model_reset();

    // Reset held while samples stream in.
    for (int i = 0; i < 20; i++) begin
      enable = 1'b1; adc_valid = 1'b1; adc_data = SW'($urandom); m_ready = 1'($urandom);
      @(posedge ACLK); #1;
    end
    check_all_zero("reset");
    ARESETN = 1'b1;
    model_reset();

    // Packing and latency.
    step(1'b1, 1'b1, 12'h001, 1'b1, 1'b0);
    step(1'b1, 1'b1, 12'h002, 1'b1, 1'b0);
    chk("pack_lat_w0_not_yet", 32'(m_valid), 32'h0);
    step(1'b1, 1'b1, 12'h003, 1'b1, 1'b0);
    chk("pack_w0", m_data, 32'h00020001);
    chk("pack_w0_vld", 32'(m_valid), 32'h1);
    step(1'b1, 1'b1, 12'h004, 1'b1, 1'b0);
    chk("pack_gap", 32'(m_valid), 32'h0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("pack_w1", m_data, 32'h00040003);
    drain();

    // Burst flag.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, SW'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("burst_fill8", 32'(fill_level), 32'd8);
    chk("burst_high", 32'(burst_avail), 32'h1);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("burst_fill7", 32'(fill_level), 32'd7);
    chk("burst_low", 32'(burst_avail), 32'h0);
    drain();

    // Overflow, clear, and push+pop while full.
    for (int i = 0; i < 66; i++) step(1'b1, 1'b1, SW'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("ovf_fill32", 32'(fill_level), 32'd32);
    chk("ovf_set", 32'(overflow), 32'h1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'h0);
    step(1'b1, 1'b1, SW'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, SW'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("full_pushpop_fill", 32'(fill_level), 32'd32);
    chk("full_pushpop_ovf", 32'(overflow), 32'h0);
    step(1'b1, 1'b1, SW'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, SW'($urandom), 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow), 32'h1);

    // Asynchronous reset mid-operation.
    ARESETN = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    model_reset();

    // Enable abort discards the orphan half.
    step(1'b1, 1'b1, 12'h005, 1'b0, 1'b0);
    step(1'b0, 1'b1, SW'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, 12'h00A, 1'b0, 1'b0);
    step(1'b1, 1'b1, 12'h00B, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("abort_word", m_data, 32'h000B000A);
    chk("abort_fill", 32'(fill_level), 32'd1);
    drain();

    // Random traffic: slow consumer, then fast consumer.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 3) != 0), SW'($urandom),
           (i < 200) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0));
    end
    drain();

`ifdef ADC_PACK_TLAST_EN
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, SW'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      chk("tlast_beat", 32'(m_last), 32'((k % BURST) == 0));
      step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    end
    chk("tlast_empty", 32'(m_valid), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
